// File: rtl/reqc_s_rd_burst_if.sv
// Bundle for the read executor: request-queue head/pop, single-port SRAM
// read port and the r_* read-data channel. "slave" is the executor side,
// "master" is the surrounding queue / SRAM / consumer.
interface reqc_s_rd_burst_if #(
    parameter int ADR_W  = 10,
    parameter int DATA_W = 32
);
    // Request queue head and pop strobe
    logic              reqc_s_valid;
    logic [3:0]        reqc_s_id;
    logic [31:0]       reqc_s_addr;
    logic              reqc_s_rnext;
    // SRAM read port
    logic              sram_ren;
    logic [ADR_W-1:0]  sram_radr;
    logic [DATA_W-1:0] sram_rdata;
    // Read-data channel
    logic              r_valid;
    logic              r_ready;
    logic [3:0]        r_id;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    modport slave (
        input  reqc_s_valid, reqc_s_id, reqc_s_addr, sram_rdata, r_ready,
        output reqc_s_rnext, sram_ren, sram_radr, r_valid, r_id, r_data, r_last
    );

    modport master (
        output reqc_s_valid, reqc_s_id, reqc_s_addr, sram_rdata, r_ready,
        input  reqc_s_rnext, sram_ren, sram_radr, r_valid, r_id, r_data, r_last
    );
endinterface

// File: rtl/reqc_s_rd_burst.sv
// Subordinate-side read executor. Pops one (id, addr) request, reads a
// BURST_LEN-word burst from a 1-cycle-latency SRAM and returns it on the
// r_* channel through a 2-entry buffer. SRAM reads are only issued when the
// buffer is guaranteed to have room for the returning word, so r_ready
// stalls never drop data and a steady r_ready gives one beat per cycle.
module reqc_s_rd_burst #(
    parameter int BURST_LEN = 4,
    parameter int ADR_W     = 10,
    parameter int DATA_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    reqc_s_rd_burst_if.slave   bus
);
    localparam int CNT_W  = $clog2(BURST_LEN + 1);
    localparam int BEAT_W = $clog2(BURST_LEN);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [3:0]          r_cur_id;
    logic [ADR_W-1:0]    r_cur_adr;
    logic [CNT_W-1:0]    r_issue_cnt;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_inflight;

    logic [DATA_W-1:0]   r_buf [2];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_occ;

    logic                w_rnext;
    logic                w_ren;
    logic                w_valid;
    logic                w_pop;
    logic                w_last;
    logic                w_burst_done;
    logic                w_credit_ok;
    logic [ADR_W-1:0]    w_radr;
    logic                w_unused_addr;

    // Only the word-address field of the byte address is used.
    assign w_unused_addr = ^{bus.reqc_s_addr[31:ADR_W+2], bus.reqc_s_addr[1:0]};

    assign w_valid      = (r_occ != 2'd0);
    assign w_pop        = w_valid & bus.r_ready;
    assign w_last       = w_valid & (r_beat_cnt == BEAT_W'(BURST_LEN - 1));
    assign w_burst_done = w_pop & w_last;

    // A new read may issue only if the buffer still has a free slot after
    // counting the word already on its way back and this cycle's pop.
    assign w_credit_ok  = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

    // Word address wraps naturally modulo 2^ADR_W.
    assign w_radr       = r_cur_adr + ADR_W'(r_issue_cnt);

    assign bus.reqc_s_rnext = w_rnext;
    assign bus.sram_ren     = w_ren;
    assign bus.sram_radr    = w_ren ? w_radr : '0;
    assign bus.r_valid      = w_valid;
    assign bus.r_id         = r_cur_id;
    assign bus.r_data       = r_buf[r_rptr];
    assign bus.r_last       = w_last;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: one request per burst, back to IDLE on the last handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.reqc_s_valid) w_state_nxt = S_BURST;
            S_BURST: if (w_burst_done)     w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: single-cycle pop in IDLE, credit-gated SRAM reads in BURST
    always_comb begin
        w_rnext = 1'b0;
        w_ren   = 1'b0;
        case (r_state)
            S_IDLE:  w_rnext = bus.reqc_s_valid & rst_n;
            S_BURST: w_ren   = (r_issue_cnt < CNT_W'(BURST_LEN)) & w_credit_ok;
            default: ;
        endcase
    end

    // Latch the popped request and track issued reads / delivered beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_id    <= '0;
            r_cur_adr   <= '0;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
        end else if (w_rnext) begin
            r_cur_id    <= bus.reqc_s_id;
            r_cur_adr   <= bus.reqc_s_addr[ADR_W+1:2];
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_ren) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            if (w_pop) r_beat_cnt  <= r_beat_cnt + BEAT_W'(1);
        end
    end

    // Two-entry in-order buffer: capture the SRAM word one cycle after its read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_occ      <= 2'd0;
        end else begin
            r_inflight <= w_ren;
            if (r_inflight) begin
                r_buf[r_wptr] <= bus.sram_rdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            case ({r_inflight, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reqc_s_rd_burst.sv
// Scoreboard bench for reqc_s_rd_burst: requests push expected beats into a
// queue, a monitor pops/compares on every r_* beat, and directed checks look
// at pop/read/handshake cycle logs against hand-computed schedules.
`timescale 1ns/1ps
module tb_reqc_s_rd_burst;
    localparam int BURST_LEN = 4;
    localparam int ADR_W     = 10;
    localparam int DATA_W    = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reqc_s_rd_burst_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

    reqc_s_rd_burst #(.BURST_LEN(BURST_LEN), .ADR_W(ADR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [3:0] id; logic [31:0] addr; } req_t;
    typedef struct { logic [3:0] id; logic [DATA_W-1:0] data; logic last; } beat_t;
    typedef struct { int cyc; logic [ADR_W-1:0] adr; } ren_t;

    req_t  req_q[$];
    beat_t sb[$];
    int    rnext_log[$];
    ren_t  ren_log[$];
    int    hs_log[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_cnt = 0;
    int rdy_mode = 0;   // 0: always ready, 1: stall window after pop, 2: random
    bit prev_rnext = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM contents: every word tagged with its own address
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADR_W-1:0] a);
        return 32'hC0DE_0000 | {22'h0, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] id, input logic [31:0] addr);
        req_t r;
        r.id = id;
        r.addr = addr;
        req_q.push_back(r);
        for (int i = 0; i < BURST_LEN; i++) begin
            beat_t b;
            b.id   = id;
            b.data = mem_word(addr[ADR_W+1:2] + ADR_W'(i));
            b.last = (i == BURST_LEN - 1);
            sb.push_back(b);
        end
    endtask

    task automatic clear_logs();
        rnext_log.delete();
        ren_log.delete();
        hs_log.delete();
        last_cnt = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while ((req_q.size() != 0 || sb.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({name, "_done_in_budget"}, 64'(k < budget), 64'd1);
        repeat (3) @(posedge clk);
    endtask

    // Environment: request queue, 1-cycle SRAM and r_ready generator
    initial begin
        bit s_rnext;
        bit s_ren;
        logic [ADR_W-1:0] s_radr;
        bus.reqc_s_valid = 1'b0;
        bus.reqc_s_id    = '0;
        bus.reqc_s_addr  = '0;
        bus.sram_rdata   = '0;
        bus.r_ready      = 1'b1;
        forever begin
            @(negedge clk);
            s_rnext = bus.reqc_s_rnext;
            s_ren   = bus.sram_ren;
            s_radr  = bus.sram_radr;
            @(posedge clk);
            #1;
            if (s_rnext && rst_n && req_q.size() > 0) void'(req_q.pop_front());
            if (req_q.size() > 0) begin
                bus.reqc_s_valid = 1'b1;
                bus.reqc_s_id    = req_q[0].id;
                bus.reqc_s_addr  = req_q[0].addr;
            end else begin
                bus.reqc_s_valid = 1'b0;
            end
            bus.sram_rdata = s_ren ? mem_word(s_radr) : 32'hBAD0_BAD0;
            case (rdy_mode)
                1: bus.r_ready = !(rnext_log.size() > 0 &&
                                   cyc >= rnext_log[0] + 3 && cyc <= rnext_log[0] + 8);
                2: bus.r_ready = 1'($urandom_range(0, 1));
                default: bus.r_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compare every presented beat with the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.reqc_s_rnext) begin
                    check("rnext_not_consecutive", 64'(prev_rnext), 64'd0);
                    rnext_log.push_back(cyc);
                end
                prev_rnext = bus.reqc_s_rnext;
                if (bus.sram_ren) begin
                    ren_t e;
                    e.cyc = cyc;
                    e.adr = bus.sram_radr;
                    ren_log.push_back(e);
                end
                if (bus.r_valid) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %0h, no beat expected", bus.r_data);
                    end else begin
                        check("r_id",   64'(bus.r_id),   64'(sb[0].id));
                        check("r_data", 64'(bus.r_data), 64'(sb[0].data));
                        check("r_last", 64'(bus.r_last), 64'(sb[0].last));
                        if (bus.r_ready) begin
                            void'(sb.pop_front());
                            hs_log.push_back(cyc);
                            if (bus.r_last) last_cnt++;
                        end
                    end
                end
            end else begin
                prev_rnext = 1'b0;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rnext"},   64'(bus.reqc_s_rnext), 64'd0);
        check({tag, "_ren"},     64'(bus.sram_ren),     64'd0);
        check({tag, "_radr"},    64'(bus.sram_radr),    64'd0);
        check({tag, "_r_valid"}, 64'(bus.r_valid),      64'd0);
        check({tag, "_r_last"},  64'(bus.r_last),       64'd0);
        check({tag, "_r_id"},    64'(bus.r_id),         64'd0);
        check({tag, "_r_data"},  64'(bus.r_data),       64'd0);
    endtask

    // Directed sequence
    initial begin
        int t;
        int n;
        int k;
        logic [ADR_W-1:0] wrap_exp [4];
        wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single request, r_ready always 1
        clear_logs();
        rdy_mode = 0;
        send(4'h5, 32'h0000_0100);
        wait_done("single", 100);
        check("single_rnext_cnt", 64'(rnext_log.size()), 64'd1);
        check("single_ren_cnt", 64'(ren_log.size()), 64'd4);
        check("single_hs_cnt", 64'(hs_log.size()), 64'd4);
        check("single_last_cnt", 64'(last_cnt), 64'd1);
        if (rnext_log.size() > 0) begin
            t = rnext_log[0];
            for (int i = 0; i < 4 && i < ren_log.size(); i++) begin
                check("single_ren_cyc", 64'(ren_log[i].cyc - t), 64'(1 + i));
                check("single_radr", 64'(ren_log[i].adr), 64'(10'h040 + i));
            end
            for (int i = 0; i < 4 && i < hs_log.size(); i++)
                check("single_beat_cyc", 64'(hs_log[i] - t), 64'(3 + i));
        end

        // Backpressure: r_ready low from T+3 to T+8
        clear_logs();
        rdy_mode = 1;
        send(4'h5, 32'h0000_0100);
        wait_done("bp", 100);
        rdy_mode = 0;
        check("bp_ren_cnt", 64'(ren_log.size()), 64'd4);
        check("bp_hs_cnt", 64'(hs_log.size()), 64'd4);
        if (rnext_log.size() > 0) begin
            t = rnext_log[0];
            n = 0;
            for (int i = 0; i < ren_log.size(); i++)
                if (ren_log[i].cyc <= t + 8) n++;
            check("bp_ren_during_stall", 64'(n), 64'd2);
            if (ren_log.size() == 4) begin
                check("bp_ren2_cyc", 64'(ren_log[2].cyc - t), 64'd9);
                check("bp_ren3_cyc", 64'(ren_log[3].cyc - t), 64'd10);
            end
            for (int i = 0; i < 4 && i < hs_log.size(); i++)
                check("bp_beat_cyc", 64'(hs_log[i] - t), 64'(9 + i));
        end

        // Back-to-back requests
        clear_logs();
        send(4'h1, 32'h0000_0000);
        send(4'h2, 32'h0000_0040);
        wait_done("b2b", 200);
        check("b2b_rnext_cnt", 64'(rnext_log.size()), 64'd2);
        check("b2b_last_cnt", 64'(last_cnt), 64'd2);
        if (rnext_log.size() == 2 && hs_log.size() == 8)
            check("b2b_second_pop_cyc", 64'(rnext_log[1] - hs_log[3]), 64'd1);
        if (ren_log.size() == 8)
            for (int i = 0; i < 4; i++)
                check("b2b_id2_radr", 64'(ren_log[4 + i].adr), 64'(10'h010 + i));

        // Word-address wrap
        clear_logs();
        send(4'hA, 32'h0000_0FF8);
        wait_done("wrap", 100);
        check("wrap_ren_cnt", 64'(ren_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < ren_log.size(); i++)
            check("wrap_radr", 64'(ren_log[i].adr), 64'(wrap_exp[i]));

        // Random r_ready over 20 requests
        clear_logs();
        rdy_mode = 2;
        for (int i = 0; i < 20; i++)
            send(4'($urandom_range(0, 15)), $urandom);
        wait_done("random", 3000);
        rdy_mode = 0;
        check("random_rnext_cnt", 64'(rnext_log.size()), 64'd20);
        check("random_last_cnt", 64'(last_cnt), 64'd20);
        check("random_hs_cnt", 64'(hs_log.size()), 64'd80);

        // Reset mid-burst after the first beat is accepted
        clear_logs();
        send(4'h7, 32'h0000_0200);
        k = 0;
        while (hs_log.size() < 1 && k < 50) begin
            @(posedge clk);
            k++;
        end
        check("rst_first_beat_seen", 64'(k < 50), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        sb.delete();
        req_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (10) @(posedge clk);
        #2;
        check("post_rst_rnext_cnt", 64'(rnext_log.size()), 64'd0);
        check("post_rst_ren_cnt", 64'(ren_log.size()), 64'd0);
        check("post_rst_hs_cnt", 64'(hs_log.size()), 64'd0);
        check("post_rst_r_valid", 64'(bus.r_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reqc_s_rd_burst.md
Name: reqc_s_rd_burst

Overview:
- Subordinate-side read executor. Sits directly downstream of the subordinate request-channel queue.
- Pops one queued request (id, addr) at a time and reads a fixed-length burst from a single-port synchronous SRAM.
- Returns the data on a valid/ready read-data channel (r_*) tagged with the request id, with r_last on the final beat.
- A 2-entry output buffer absorbs the SRAM read latency, so r_ready stalls lose no data and a continuous r_ready gives one beat per cycle.

Parameters:
- BURST_LEN, 4, beats per request (2..16).
- ADR_W, 10, SRAM word-address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- reqc_s_valid  in  1  request queue non-empty
- reqc_s_id  in  4  id of head request; valid while reqc_s_valid=1
- reqc_s_addr  in  32  byte address of head request; valid while reqc_s_valid=1
- reqc_s_rnext  out  1  pop pulse to request queue
- sram_ren  out  1  SRAM read enable
- sram_radr  out  ADR_W  SRAM word address
- sram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after sram_ren
- r_valid  out  1  read beat valid
- r_ready  in  1  read beat accepted
- r_id  out  4  id of current burst
- r_data  out  DATA_W  beat data
- r_last  out  1  final beat of burst

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. While reset is asserted:
  - reqc_s_rnext, sram_ren, r_valid and r_last are 0.
  - sram_radr, r_id and r_data are 0.
  - FSM is in IDLE; the output buffer is emptied; all counters are cleared.
- Reset mid-burst aborts the burst. Remaining beats are discarded, and the popped request is not replayed.
- FSM states: IDLE, BURST.
- IDLE:
  - When reqc_s_valid=1, assert reqc_s_rnext for exactly one cycle.
  - In that same cycle, latch cur_id=reqc_s_id and cur_adr=reqc_s_addr[ADR_W+1:2]. Clear issue_cnt and beat_cnt, then go to BURST.
  - reqc_s_rnext is never asserted outside IDLE and never for 2 consecutive cycles.
- BURST, issue side:
  - sram_ren=1 when issue_cnt<BURST_LEN and (occ + inflight - pop) < 2.
    - occ is the number of buffered entries (0..2).
    - inflight=1 if sram_ren was asserted in the previous cycle.
    - pop = r_valid & r_ready.
  - sram_radr = cur_adr + issue_cnt, computed modulo 2^ADR_W (word address wraps, no error).
  - issue_cnt increments on each sram_ren.
  - reqc_s_addr[1:0] is ignored.
- Capture: when inflight=1, sram_rdata is written into the output buffer at the end of that cycle. This write never overflows, because of the credit rule above.
- Output:
  - r_valid = (occ>0). r_data is the head buffer entry, in order. r_id = cur_id.
  - r_last = r_valid & (beat_cnt == BURST_LEN-1).
  - beat_cnt increments on pop. r_data, r_id and r_last are held stable while r_valid=1 and r_ready=0.
- Latency: pop cycle T → first sram_ren at T+1 → first r_valid at T+3.
  - With r_ready held at 1, beats arrive on consecutive cycles T+3 .. T+2+BURST_LEN.
- End of burst: on the cycle with r_valid & r_ready & r_last, return to IDLE.
  - The next pop can occur in the following cycle, if reqc_s_valid=1.
  - No overlap between bursts. The queue's valid has settled by then, because at least BURST_LEN+2 cycles separate pops.
- Simultaneous capture and pop in one cycle: occ is unchanged, and buffer order is preserved.
- r_ready=1 while r_valid=0 has no effect.

Test Plan:
- Single request, r_ready=1: reqc_s_valid=1, id=4'h5, addr=32'h0000_0100 for 1 cycle.
  - Expect rnext one pulse at T.
  - Expect sram_radr 0x40,0x41,0x42,0x43 at T+1..T+4.
  - Expect r_valid T+3..T+6 carrying SRAM words 0x40..0x43, r_id=5, r_last only at T+6, then IDLE.
- Backpressure: same request, but r_ready=0 from T+3 to T+8, then 1.
  - Expect sram_ren to stop after 2 issues (occ=2).
  - Expect r_data to hold word 0x40 until accepted.
  - Expect all 4 beats delivered in order, none dropped or duplicated.
- Back-to-back: queue holds id 1 (addr 0x0) and id 2 (addr 0x40).
  - Expect the second rnext exactly one cycle after id 1's r_last handshake.
  - Expect id 2's beats to read words 0x10..0x13.
- Address wrap: addr=(2^ADR_W-2)*4.
  - Expect sram_radr 0x3FE, 0x3FF, 0x000, 0x001.
- Random r_ready toggling (50%) over 20 requests: check data order, r_last count = 20, and one rnext per request.
- Reset asserted mid-burst, after beat 1 is accepted.
  - Expect all outputs 0 immediately.
  - After release with reqc_s_valid=0, expect the block to stay IDLE with no r_valid.
